// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - mode encodings and counter sizing for the universal shift register
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    // Counter must be able to represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shreg_if.sv
// rtl/shreg_if.sv - control, data and serial signals of the universal shift register
interface shreg_if #(
    parameter int WIDTH = 8
);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             sout_l;
    logic             sout_r;
    logic             word_rdy;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, nq, sout_l, sout_r, word_rdy
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, nq, sout_l, sout_r, word_rdy
    );

endinterface

// File: rtl/shreg_cnt.sv
// rtl/shreg_cnt.sv - shift-event counter with a one-period word-complete pulse
module shreg_cnt
    import shreg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    input  logic                    clr,
    output logic [cnt_width(N)-1:0] cnt,
    output logic                    word_rdy
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;

    // Counts shift events, not bit position; clr wins over inc.
    always_comb begin
        cnt_d = cnt_q;
        rdy_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                rdy_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign cnt      = cnt_q;
    assign word_rdy = rdy_q;

endmodule

// File: rtl/shreg_r.sv
// rtl/shreg_r.sv - universal shift register, falling-edge, async active-high reset
module shreg_r
    import shreg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic     clk,
    input  logic     rst,
    shreg_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_w;
    logic             word_rdy_w;
    logic             is_shift;
    logic             is_restart;

    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = bus.d;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.sin_r};
                MODE_SHR:  q_d = {bus.sin_l, q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_CLR:  q_d = RST_VAL;
                MODE_INV:  q_d = ~q_q;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign is_shift   = bus.en && (bus.mode == MODE_SHL || bus.mode == MODE_SHR ||
                                   bus.mode == MODE_ROL || bus.mode == MODE_ROR);
    assign is_restart = bus.en && (bus.mode == MODE_LOAD || bus.mode == MODE_CLR);

    shreg_cnt #(
        .N (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (is_shift),
        .clr      (is_restart),
        .cnt      (cnt_w),
        .word_rdy (word_rdy_w)
    );

    assign bus.q        = q_q;
    assign bus.nq       = ~q_q;
    assign bus.sout_l   = q_q[WIDTH-1];
    assign bus.sout_r   = q_q[0];
    assign bus.word_rdy = word_rdy_w;

endmodule
